// File: rtl/sample_mem_writer.sv
// rtl/sample_mem_writer.sv - toggle-request FIFO draining into Avalon-MM sample memory writes
// Optional feature: define SAMPLE_WR_AUTOINC_EN to add the wr_autoinc address counter.

module sample_mem_writer #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_toggle,
`ifdef SAMPLE_WR_AUTOINC_EN
    input  logic              wr_autoinc,
`endif
    input  logic              clear_overflow,
    output logic              wr_ack_toggle,
    output logic              fifo_full,
    output logic              overflow,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_write,
    input  logic              mem_waitrequest
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    logic              tog_q;
    logic              req;
    logic              push;
    logic              pop;
    logic [0:0]        state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;
    logic [ADDR_W-1:0] push_addr;
    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

    assign req  = (wr_toggle != tog_q);
    assign pop  = (state == ST_IDLE) && (count != '0);
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push = req && ((count != FULL_CNT) || pop);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count - CNT_ONE;
        end
    end

`ifdef SAMPLE_WR_AUTOINC_EN
    logic [ADDR_W-1:0] inc_addr;

    assign push_addr = wr_autoinc ? inc_addr : wr_address;

    // Advances on every request, including ones dropped by a full FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            inc_addr <= '0;
        end else if (req) begin
            inc_addr <= push_addr + ADDR_W'(1);
        end
    end
`else
    assign push_addr = wr_address;
`endif

    // Loads during reset too, so a toggle held across reset is not a request.
    always_ff @(posedge clk) begin
        tog_q <= wr_toggle;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            fifo_full     <= 1'b0;
            overflow      <= 1'b0;
            state         <= ST_IDLE;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            wr_ack_toggle <= 1'b0;
        end else begin
            count     <= count_next;
            fifo_full <= (count_next == FULL_CNT);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (req && !push) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        mem_address   <= addr_mem[rd_ptr];
                        mem_writedata <= data_mem[rd_ptr];
                        rd_ptr        <= rd_ptr + PTR_ONE;
                        mem_write     <= 1'b1;
                        state         <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!mem_waitrequest) begin
                        mem_write     <= 1'b0;
                        wr_ack_toggle <= ~wr_ack_toggle;
                        state         <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_mem_writer.sv
// tb/tb_sample_mem_writer.sv - self-checking bench for sample_mem_writer
// Optional feature: define SAMPLE_WR_AUTOINC_EN to exercise wr_autoinc.

module tb_sample_mem_writer;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] wr_address;
    logic [DATA_W-1:0] wr_data;
    logic              wr_toggle;
    logic              wr_autoinc;
    logic              clear_overflow;
    logic              wr_ack_toggle;
    logic              fifo_full;
    logic              overflow;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_write;
    logic              mem_waitrequest;

    sample_mem_writer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_address(wr_address),
        .wr_data(wr_data),
        .wr_toggle(wr_toggle),
`ifdef SAMPLE_WR_AUTOINC_EN
        .wr_autoinc(wr_autoinc),
`endif
        .clear_overflow(clear_overflow),
        .wr_ack_toggle(wr_ack_toggle),
        .fifo_full(fifo_full),
        .overflow(overflow),
        .mem_address(mem_address),
        .mem_writedata(mem_writedata),
        .mem_write(mem_write),
        .mem_waitrequest(mem_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                wait_cyc;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
        int                exp_high;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    logic exp_ack;
    req_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        mem_waitrequest = 1'b0;
        clear_overflow  = 1'b0;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        exp_ack = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_req(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit keep);
        req_t r;
        wr_address = a;
        wr_data    = d;
        wr_toggle  = ~wr_toggle;
        r.addr = a;
        r.data = d;
        if (keep) exp_q.push_back(r);
    endtask

    // Waitrequest low for the whole window: every visible mem_write is an accept.
    task automatic drain(input int cycles, output int n);
        req_t e;
        n = 0;
        mem_waitrequest = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (mem_write) begin
                n++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h expected no write", mem_address);
                end else begin
                    e = exp_q.pop_front();
                    chk("drain_addr", 32'(mem_address), 32'(e.addr));
                    chk("drain_data", 32'(mem_writedata), 32'(e.data));
                end
                exp_ack = ~exp_ack;
            end
            @(negedge clk);
        end
        chk("drain_ack", 32'(wr_ack_toggle), 32'(exp_ack));
    endtask

    vec_t vecs[4];

    initial begin
        int   n;
        int   hc;
        int   budget;
        int   outstanding;
        bit   stalled;
        logic [ADDR_W-1:0] prev_a;
        logic [DATA_W-1:0] prev_d;
        req_t e;

        wr_address = '0;
        wr_data    = '0;
        wr_toggle  = 1'b0;
        wr_autoinc = 1'b0;

        vecs[0] = '{17'h1ABCD, 16'h1234, 0, 17'h1ABCD, 16'h1234, 1};
        vecs[1] = '{17'h00000, 16'hFFFF, 5, 17'h00000, 16'hFFFF, 6};
        vecs[2] = '{17'h1FFFF, 16'h0000, 1, 17'h1FFFF, 16'h0000, 2};
        vecs[3] = '{17'h0A5A5, 16'h5A5A, 3, 17'h0A5A5, 16'h5A5A, 4};

        do_reset();
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_ack", 32'(wr_ack_toggle), 0);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_addr", 32'(mem_address), 0);
        chk("rst_data", 32'(mem_writedata), 0);

        // Single writes with stalls: latency, stability and ack timing.
        for (int v = 0; v < 4; v++) begin
            send_req(vecs[v].addr, vecs[v].data, 1'b0);
            mem_waitrequest = (vecs[v].wait_cyc > 0);
            @(negedge clk);
            chk("lat_e0", 32'(mem_write), 0);
            @(negedge clk);
            hc = 0;
            budget = 0;
            while (mem_write && budget < 50) begin
                chk("vec_addr", 32'(mem_address), 32'(vecs[v].exp_addr));
                chk("vec_data", 32'(mem_writedata), 32'(vecs[v].exp_data));
                chk("vec_ack_hold", 32'(wr_ack_toggle), 32'(exp_ack));
                hc++;
                mem_waitrequest = (hc <= vecs[v].wait_cyc);
                @(negedge clk);
                budget++;
            end
            exp_ack = ~exp_ack;
            chk("vec_high_cycles", hc, vecs[v].exp_high);
            chk("vec_ack", 32'(wr_ack_toggle), 32'(exp_ack));
            mem_waitrequest = 1'b0;
            @(negedge clk);
        end

        // Overflow: six requests against a stalled memory, last one lost.
        do_reset();
        mem_waitrequest = 1'b1;
        for (int k = 0; k < 6; k++) begin
            send_req(17'h100 + 17'(k), 16'hA000 + 16'(k), k < 5);
            @(negedge clk);
        end
        chk("ovf_full", 32'(fifo_full), 1);
        chk("ovf_flag", 32'(overflow), 1);
        drain(20, n);
        chk("ovf_writes", n, 5);
        chk("ovf_q_empty", exp_q.size(), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ovf_full_clr", 32'(fifo_full), 0);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);

        // Push at full on the same edge the head is popped.
        do_reset();
        mem_waitrequest = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send_req(17'h200 + 17'(k), 16'hB000 + 16'(k), 1'b1);
            @(negedge clk);
        end
        chk("pp_full", 32'(fifo_full), 1);
        chk("pp_ovf0", 32'(overflow), 0);
        chk("pp_inflight", 32'(mem_write), 1);
        e = exp_q.pop_front();
        chk("pp_head_addr", 32'(mem_address), 32'(e.addr));
        exp_ack = ~exp_ack;
        mem_waitrequest = 1'b0;
        @(negedge clk);
        chk("pp_idle", 32'(mem_write), 0);
        send_req(17'h1F00F, 16'hCAFE, 1'b1);
        @(negedge clk);
        chk("pp_ovf_stays0", 32'(overflow), 0);
        chk("pp_still_full", 32'(fifo_full), 1);
        drain(20, n);
        chk("pp_writes", n, 5);
        chk("pp_q_empty", exp_q.size(), 0);

        // Reset hygiene: toggle held high through reset.
        wr_toggle = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
        wr_toggle = 1'b1;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        exp_ack = 1'b0;
        hc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_write) hc++;
        end
        chk("rh_no_write", hc, 0);
        chk("rh_ack", 32'(wr_ack_toggle), 0);

        // Reset during WRITE abandons the write without ack.
        mem_waitrequest = 1'b1;
        send_req(17'h0BEEF, 16'h7777, 1'b0);
        repeat (2) @(negedge clk);
        chk("rw_inflight", 32'(mem_write), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rw_mem_write0", 32'(mem_write), 0);
        chk("rw_ack0", 32'(wr_ack_toggle), 0);
        chk("rw_full0", 32'(fifo_full), 0);
        mem_waitrequest = 1'b0;
        hc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_write) hc++;
        end
        chk("rw_fifo_empty", hc, 0);
        chk("rw_no_ack", 32'(wr_ack_toggle), 0);

        // Random traffic within the outstanding-request contract.
        do_reset();
        outstanding = 0;
        stalled = 1'b0;
        prev_a = '0;
        prev_d = '0;
        for (int c = 0; c < 400; c++) begin
            chk("rnd_ack", 32'(wr_ack_toggle), 32'(exp_ack));
            if (stalled) begin
                chk("rnd_stall_write", 32'(mem_write), 1);
                chk("rnd_stall_addr", 32'(mem_address), 32'(prev_a));
                chk("rnd_stall_data", 32'(mem_writedata), 32'(prev_d));
            end
            mem_waitrequest = ($urandom_range(0, 2) == 0);
            if (mem_write && !mem_waitrequest) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_unexpected_write: got addr %h expected no write", mem_address);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_addr", 32'(mem_address), 32'(e.addr));
                    chk("rnd_data", 32'(mem_writedata), 32'(e.data));
                end
                outstanding--;
                exp_ack = ~exp_ack;
            end
            stalled = mem_write && mem_waitrequest;
            prev_a  = mem_address;
            prev_d  = mem_writedata;
            if (outstanding < DEPTH && $urandom_range(0, 1) == 1) begin
                send_req(ADDR_W'($urandom), DATA_W'($urandom), 1'b1);
                outstanding++;
            end
            @(negedge clk);
        end
        drain(40, n);
        chk("rnd_q_empty", exp_q.size(), 0);
        chk("rnd_overflow", 32'(overflow), 0);

`ifdef SAMPLE_WR_AUTOINC_EN
        do_reset();
        wr_autoinc = 1'b0;
        send_req(17'h1FFFE, 16'h0001, 1'b0);
        exp_q.push_back({17'h1FFFE, 16'h0001});
        @(negedge clk);
        wr_autoinc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_req(ADDR_W'($urandom), 16'h0002 + 16'(k), 1'b0);
            @(negedge clk);
        end
        wr_autoinc = 1'b0;
        exp_q.push_back({17'h1FFFF, 16'h0002});
        exp_q.push_back({17'h00000, 16'h0003});
        exp_q.push_back({17'h00001, 16'h0004});
        drain(20, n);
        chk("ai_writes", n, 4);
        chk("ai_q_empty", exp_q.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_mem_writer.md
# sample_mem_writer

Downstream consumer of the NIOS write-address PIO (17-bit) and its companion data/strobe PIOs. Detects each software write request (toggle protocol), buffers {address, data} pairs in a small FIFO, and drains them as Avalon-MM-style writes into the sample memory. Returns a completion toggle and sticky overflow flag to NIOS input PIOs.

## Interface
Parameters:
- ADDR_W, 17, write address width; matches the address PIO.
- DATA_W, 16, sample word width.
- FIFO_DEPTH, 4, request buffer entries; power of two, ≥2.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- wr_address  in  ADDR_W  target address from the address PIO.
- wr_data  in  DATA_W  sample word from the data PIO.
- wr_toggle  in  1  request strobe; each level change is one request.
- clear_overflow  in  1  one-cycle pulse; clears overflow.
- wr_ack_toggle  out  1  flips once per completed memory write.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- overflow  out  1  sticky; a request was dropped.
- mem_address  out  ADDR_W  memory write address.
- mem_writedata  out  DATA_W  memory write data.
- mem_write  out  1  write request; held until accepted.
- mem_waitrequest  in  1  memory stall; write accepted at an edge where mem_write=1 and mem_waitrequest=0.

## Operation
- Request detect: tog_q <= wr_toggle every cycle; req = (wr_toggle != tog_q). During reset tog_q loads wr_toggle, so no spurious request at reset release.
- Push: on edge with req=1, {wr_address, wr_data} written to FIFO tail if not full. If full and no pop in the same cycle, request dropped, overflow <= 1.
- Full with simultaneous pop: push accepted, occupancy unchanged.
- overflow: set has priority over clear_overflow in the same cycle.
- FSM, two states:
  - IDLE: mem_write=0. If FIFO non-empty: pop head into mem_address/mem_writedata, mem_write <= 1, go WRITE.
  - WRITE: hold mem_address/mem_writedata/mem_write stable. On edge with mem_waitrequest=0: mem_write <= 0, wr_ack_toggle flips, go IDLE.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
- fifo_full is registered and derived from the occupancy counter.
- Reset: all outputs 0, FIFO empty, FSM in IDLE; in-flight write abandoned with no ack.

## Timing
- Request edge E0 (push) -> mem_write high after E1 -> earliest accept at E2 -> wr_ack_toggle flips after E2.
- One bubble cycle in IDLE between writes; peak throughput is one write per 2 cycles.
- Software contract: no more than FIFO_DEPTH toggles outstanding without acks. Toggling faster than one per cycle is impossible by construction.
- mem_address/mem_writedata change only on the IDLE->WRITE transition.

## Configuration
- SAMPLE_WR_AUTOINC_EN defined: adds input port wr_autoinc (1 bit).
  - Every request while wr_autoinc=0 uses wr_address and loads an internal counter with wr_address+1.
  - Every request while wr_autoinc=1 uses the counter value, then increments the counter, wrapping at 2^ADDR_W.
  - The counter resets to 0. The stored FIFO address is the resolved address.
- SAMPLE_WR_AUTOINC_EN not defined: no wr_autoinc port, no counter; every request uses wr_address.

## Test plan
- Single write: reset, toggle with addr=0x1ABCD, data=0x1234, waitrequest=0 -> mem_write high exactly one cycle 2 edges later with addr=0x1ABCD, data=0x1234; ack flips once.
- Stall: waitrequest held high 5 cycles -> mem_write, address and data stable all 5 cycles; ack flips only after the accepting edge.
- Overflow: waitrequest=1, 6 toggles with FIFO_DEPTH=4 -> fifo_full=1, overflow=1. Release waitrequest -> exactly 5 writes: 1 in flight + 4 buffered; the last request is lost. clear_overflow -> overflow=0.
- Reset hygiene: hold wr_toggle=1 through reset -> no write after release. Assert reset during WRITE -> mem_write=0 next cycle, FIFO empty, no ack.
- Simultaneous push/pop at full: FIFO full, write accepted in the same cycle as a new toggle -> request accepted, overflow stays 0.
- Autoinc (macro on): toggle with wr_address=0x1FFFE and autoinc=0, then 3 toggles with autoinc=1 -> writes to 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
